cordic_vectoring: RTL and testbench



---
 rtl/cordic_pkg.sv | 28 ++
 rtl/vec_scale.sv | 23 ++
 rtl/cordic_vectoring.sv | 148 ++++++++++++++
 tb/tb_cordic_vectoring.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC angle format, atan table, gain-correction shifts and FSM states
// Imported by both the rotation and vectoring paths so they agree on angle encoding.
package cordic_pkg;

  localparam int ANG_W   = 12;
  localparam int FRAC    = 9;
  localparam int HALF_PI = 804;
  localparam int ATAN_N  = 8;

  localparam int SH_A = 1;
  localparam int SH_B = 3;
  localparam int SH_C = 6;
  localparam int SH_D = 9;

  // atan(2^-i) in radians scaled by 2^FRAC
  localparam logic [ANG_W-1:0] ATAN [ATAN_N] = '{
    12'd402, 12'd237, 12'd125, 12'd64, 12'd32, 12'd16, 12'd8, 12'd4
  };

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ITER,
    SCALE,
    DONE
  } state_t;

endpackage

// File: rtl/vec_scale.sv
// rtl/vec_scale.sv - combinational CORDIC gain corrector, x * ~0.6074 by shift-and-add
// Input is the converged (non-negative) x; result is truncated to W+1 unsigned bits.
module vec_scale #(
  parameter int W  = 12,
  parameter int GW = W + 2
) (
  input  logic [GW-1:0] x_in,
  output logic [W:0]    mag
);
  import cordic_pkg::*;

  logic signed [GW-1:0] xs;
  logic signed [GW-1:0] sum;
  logic                 unused_sign;

  assign xs  = signed'(x_in);
  assign sum = (xs >>> SH_A) + (xs >>> SH_B) - (xs >>> SH_C) - (xs >>> SH_D);
  assign mag = sum[W:0];

  // x is non-negative after convergence, so the sign bit carries no information
  assign unused_sign = sum[GW-1];

endmodule

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring CORDIC returning magnitude and atan2 of (x, y)
// One micro-rotation per clock, behind an in_valid/in_ready and out_valid/out_ready handshake.
module cordic_vectoring #(
  parameter int W  = 12,
  parameter int N  = 8,
  parameter int GW = W + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   mag_out,
  output logic [W-1:0] angle_out
);
  import cordic_pkg::*;

  state_t state_q, state_d;

  logic signed [GW-1:0] x_q, x_d;
  logic signed [GW-1:0] y_q, y_d;
  logic signed [W-1:0]  z_q, z_d;
  logic [2:0]           i_q, i_d;
  logic                 zero_q, zero_d;
  logic [W:0]           mag_q, mag_d;
  logic [W-1:0]         angle_q, angle_d;

  logic signed [W-1:0]  atan_i;
  logic [W:0]           mag_w;

  assign atan_i = W'(ATAN[i_q]);

  vec_scale #(
    .W  (W),
    .GW (GW)
  ) u_vec_scale (
    .x_in (x_q),
    .mag  (mag_w)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    i_d       = i_q;
    zero_d    = zero_q;
    mag_d     = mag_q;
    angle_d   = angle_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = {{(GW-W){x_in[W-1]}}, x_in};
          y_d     = {{(GW-W){y_in[W-1]}}, y_in};
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = PRE;
        end
      end

      // Fold the left half-plane onto the right so the iterations only need +/- pi/2 range
      PRE: begin
        if (x_q[GW-1]) begin
          if (!y_q[GW-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = W'(HALF_PI);
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = W'(-HALF_PI);
          end
        end else begin
          z_d = '0;
        end
        i_d     = '0;
        state_d = ITER;
      end

      ITER: begin
        if (!y_q[GW-1]) begin
          x_d = x_q + (y_q >>> i_q);
          y_d = y_q - (x_q >>> i_q);
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - (y_q >>> i_q);
          y_d = y_q + (x_q >>> i_q);
          z_d = z_q - atan_i;
        end
        if (i_q == 3'(N - 1)) begin
          state_d = SCALE;
        end else begin
          i_d = i_q + 3'd1;
        end
      end

      // A zero vector has no defined angle; the accumulated z is meaningless there
      SCALE: begin
        mag_d   = zero_q ? '0 : mag_w;
        angle_d = zero_q ? '0 : z_q;
        state_d = DONE;
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

  assign mag_out   = mag_q;
  assign angle_out = angle_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - self-checking bench for cordic_vectoring against a real-arithmetic model
// Expected magnitudes and angles come from sqrt/atan2; polar vectors stand in for the rotation path.
module tb_cordic_vectoring;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   mag_out;
  logic [W-1:0] angle_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cordic_vectoring #(
    .W  (W),
    .N  (8),
    .GW (W + 2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_cmp++;
    if (got < exp - tol || got > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", tag, got, exp, tol);
    end
  endtask

  function automatic int ref_mag(input int x, input int y);
    return int'($sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
  endfunction

  function automatic int ref_ang(input int x, input int y);
    return int'($atan2(real'(y), real'(x)) * 512.0);
  endfunction

  task automatic start_op(input int x, input int y);
    @(negedge clk);
    check("in_ready_before_op", int'(in_ready), 1, 0);
    x_in     = x[W-1:0];
    y_in     = y[W-1:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int mag, output int ang, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("result_timeout", 0, 1, 0);
    mag = int'(mag_out);
    ang = int'($signed(angle_out));
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_handoff", int'(in_ready), 1, 0);
    check("out_valid_after_handoff", int'(out_valid), 0, 0);
  endtask

  task automatic run_vec(input int x, input int y, output int mag, output int ang, output int lat);
    start_op(x, y);
    wait_result(mag, ang, lat);
    handoff();
  endtask

  typedef struct {
    int x;
    int y;
    int mtol;
    int atol;
  } vec_t;

  vec_t dir_tbl[7] = '{
    '{1000,     0, 12, 6},
    '{   0,  1000, 12, 6},
    '{-1000,    0, 12, 6},
    '{-707,  -707, 12, 6},
    '{2047,  2047, 30, 6},
    '{-2048, -2048, 30, 6},
    '{   0,     0,  0, 0}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int m, a, lat, hm, ha, seen, r, tl;
    real th;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1, 0);
    check("reset_out_valid", int'(out_valid), 0, 0);
    check("reset_mag", int'(mag_out), 0, 0);
    check("reset_angle", int'($signed(angle_out)), 0, 0);

    foreach (dir_tbl[k]) begin
      run_vec(dir_tbl[k].x, dir_tbl[k].y, m, a, lat);
      check("dir_latency", lat, 10, 0);
      check("dir_mag", m, ref_mag(dir_tbl[k].x, dir_tbl[k].y), dir_tbl[k].mtol);
      check("dir_angle", a, ref_ang(dir_tbl[k].x, dir_tbl[k].y), dir_tbl[k].atol);
    end

    // Back-pressure: result must hold and a stray in_valid must be dropped
    start_op(600, -800);
    wait_result(m, a, lat);
    check("bp_mag", m, 1000, 12);
    check("bp_angle", a, ref_ang(600, -800), 6);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        x_in     = 12'd100;
        y_in     = 12'd100;
        in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_out_valid", int'(out_valid), 1, 0);
      check("bp_in_ready", int'(in_ready), 0, 0);
      check("bp_mag_stable", int'(mag_out), m, 0);
      check("bp_angle_stable", int'($signed(angle_out)), a, 0);
    end
    handoff();
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    check("bp_not_captured", seen, 0, 0);
    check("bp_hold_after_handoff", int'(mag_out), m, 0);

    // Abort mid-iteration: four edges after the accept edge the block is in ITER with i = 3
    start_op(500, 300);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", int'(in_ready), 1, 0);
    check("abort_out_valid", int'(out_valid), 0, 0);
    check("abort_mag", int'(mag_out), 0, 0);
    run_vec(1000, 0, m, a, lat);
    check("post_abort_latency", lat, 10, 0);
    check("post_abort_mag", m, 1000, 12);
    check("post_abort_angle", a, 0, 6);

    // Round trip from polar form; every fourth vector has a zero rotation angle
    for (int k = 0; k < 64; k++) begin
      r  = int'($urandom_range(2000, 800));
      tl = (k % 4 == 0) ? 0 : int'($urandom_range(3000, 0)) - 1500;
      th = real'(tl) / 512.0;
      run_vec(int'(real'(r) * $cos(th)), int'(real'(r) * $sin(th)), hm, ha, lat);
      check("rt_mag", hm, r, r / 50);
      if (tl == 0) check("rt_angle_zero", ha, 0, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
